// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the load/store unit.
package lsu_pkg;

  localparam int LSU_DATA_W    = 8;
  localparam int LSU_MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request port and a data RAM.
// Build option: define LSU_BOUND_CHECK_EN to reject addresses >= MEM_DEPTH with rsp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W    = LSU_DATA_W,
  parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_mem_write,
  output logic              ram_mem_read,
  output logic [DATA_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_mem_data_in
);

`ifdef LSU_BOUND_CHECK_EN
  localparam bit BOUND_CHECK = 1'b1;
`else
  localparam bit BOUND_CHECK = 1'b0;
`endif

  // One extra bit so a MEM_DEPTH equal to 2**DATA_W still compares correctly.
  localparam logic [DATA_W:0] DEPTH_LIM = (DATA_W+1)'(MEM_DEPTH);

  state_t            state, state_next;
  logic              accept;
  logic              addr_ok;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Folds to a constant 1 when bound checking is compiled out.
  assign addr_ok = !BOUND_CHECK || ({1'b0, addr_q} < DEPTH_LIM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    ram_mem_write  = 1'b0;
    ram_mem_read   = 1'b0;
    ram_address    = '0;
    ram_write_data = '0;
    unique case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // Strobes are not gated by reset: the RAM sees this cycle's access.
        ram_address    = addr_q;
        ram_write_data = we_q ? wdata_q : '0;
        ram_mem_write  = we_q && addr_ok;
        ram_mem_read   = !we_q && addr_ok;
        state_next     = RESP;
      end
      RESP: begin
        rsp_valid = !reset;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == ACCESS) begin
      rdata_q <= (!we_q && addr_ok) ? ram_mem_data_in : '0;
      err_q   <= !addr_ok;
    end
  end

  // Response fields read as zero whenever no response is being offered.
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data RAM that clears on reset.
module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       ram_mem_write, ram_mem_read;
  logic [7:0] ram_address, ram_write_data, ram_mem_data_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram [256];

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(8), .MEM_DEPTH(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .ram_mem_write   (ram_mem_write),
    .ram_mem_read    (ram_mem_read),
    .ram_address     (ram_address),
    .ram_write_data  (ram_write_data),
    .ram_mem_data_in (ram_mem_data_in)
  );

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (ram_mem_write) begin
      ram[ram_address] <= ram_write_data;
    end
  end
  assign ram_mem_data_in = ram[ram_address];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [7:0] exp_ready);
    check({tag, ":req_ready"}, 8'(req_ready), exp_ready);
    check({tag, ":rsp_valid"}, 8'(rsp_valid), 8'h00);
    check({tag, ":rsp_rdata"}, rsp_rdata, 8'h00);
    check({tag, ":rsp_err"},   8'(rsp_err), 8'h00);
    check({tag, ":wr"},        8'(ram_mem_write), 8'h00);
    check({tag, ":rd"},        8'(ram_mem_read), 8'h00);
    check({tag, ":addr"},      ram_address, 8'h00);
    check({tag, ":wdata"},     ram_write_data, 8'h00);
  endtask

  // Issues one request from IDLE (called at edge+1) and walks it through
  // ACCESS and RESP, holding rsp_ready low for `hold` extra RESP cycles.
  task automatic do_req(input string tag, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic exp_w, input logic exp_r,
                        input logic [7:0] exp_rdata, input logic exp_err, input int hold);
    check({tag, ":idle_ready"}, 8'(req_ready), 8'h01);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    check({tag, ":acc_wr"},    8'(ram_mem_write), 8'(exp_w));
    check({tag, ":acc_rd"},    8'(ram_mem_read), 8'(exp_r));
    check({tag, ":acc_addr"},  ram_address, addr);
    check({tag, ":acc_wdata"}, ram_write_data, we ? wdata : 8'h00);
    check({tag, ":acc_ready"}, 8'(req_ready), 8'h00);
    check({tag, ":acc_rspv"},  8'(rsp_valid), 8'h00);
    tick();
    check({tag, ":rsp_valid"}, 8'(rsp_valid), 8'h01);
    check({tag, ":rsp_rdata"}, rsp_rdata, exp_rdata);
    check({tag, ":rsp_err"},   8'(rsp_err), 8'(exp_err));
    check({tag, ":rsp_wr"},    8'(ram_mem_write), 8'h00);
    check({tag, ":rsp_rd"},    8'(ram_mem_read), 8'h00);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = 8'hFF;
      tick();
      check($sformatf("%s:hold%0d_valid", tag, i), 8'(rsp_valid), 8'h01);
      check($sformatf("%s:hold%0d_rdata", tag, i), rsp_rdata, exp_rdata);
      check($sformatf("%s:hold%0d_ready", tag, i), 8'(req_ready), 8'h00);
      check($sformatf("%s:hold%0d_wr", tag, i),    8'(ram_mem_write), 8'h00);
    end
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_quiet({tag, ":done"}, 8'h01);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
    req_wdata = 8'h00; rsp_ready = 1'b0;
    tick();
    check_quiet("reset", 8'h00);
    tick();
    reset = 1'b0;
    #1;
    check_quiet("post_reset", 8'h01);

    do_req("st05", 1'b1, 8'h05, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 0);
    do_req("ld05", 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 0);
    do_req("ld05_hold", 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 4);
    // The store attempts issued during the hold must not have landed.
    do_req("ld05_again", 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 0);

    do_req("st3f", 1'b1, 8'h3F, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 0);
    do_req("ld3f", 1'b0, 8'h3F, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 0);

`ifdef LSU_BOUND_CHECK_EN
    do_req("ld40", 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0);
    do_req("st41", 1'b1, 8'h41, 8'h99, 1'b0, 1'b0, 8'h00, 1'b1, 0);
    do_req("ldff", 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 0);
`else
    do_req("ld40", 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 0);
    do_req("st41", 1'b1, 8'h41, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0, 0);
    do_req("ld41", 1'b0, 8'h41, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0, 0);
`endif

    // Reset during ACCESS of a store: strobe still shown, then no response.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h77;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    reset = 1'b1;
    #1;
    check("rst_acc:wr",    8'(ram_mem_write), 8'h01);
    check("rst_acc:addr",  ram_address, 8'h10);
    check("rst_acc:ready", 8'(req_ready), 8'h00);
    check("rst_acc:rspv",  8'(rsp_valid), 8'h00);
    tick();
    check_quiet("rst_idle", 8'h00);
    reset = 1'b0;
    #1;
    check_quiet("rst_release", 8'h01);
    tick();
    check_quiet("rst_no_rsp", 8'h01);
    do_req("ld10", 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 0);
    do_req("ld05_cleared", 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
